// File: rtl/packet_struct_pkg.sv
// Packet header types shared by the TCP RX path.
package packet_struct_pkg;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  raw_data_offset;
    logic [2:0]  reserved;
    logic [8:0]  flags;
    logic [15:0] win_size;
    logic [15:0] chksum;
    logic [15:0] urg_pointer;
  } tcp_pkt_hdr;

endpackage

// File: rtl/tcp_pkg.sv
// TCP RX widths, tmp-buffer entry type and drain FSM states.
package tcp_pkg;

  localparam int IP_ADDR_W             = 32;
  localparam int TOT_LEN_W             = 16;
  localparam int MAC_INTERFACE_W       = 256;
  localparam int MAC_INTERFACE_BYTES   = MAC_INTERFACE_W / 8;
  localparam int MAC_INTERFACE_BYTES_W = $clog2(MAC_INTERFACE_BYTES);
  localparam int MAC_PADBYTES_W        = MAC_INTERFACE_BYTES_W;
  localparam int RX_TMP_BUF_ADDR_W     = 12;
  localparam int RX_TMP_BUF_MEM_ADDR_W = RX_TMP_BUF_ADDR_W - MAC_INTERFACE_BYTES_W;

  typedef struct packed {
    logic [RX_TMP_BUF_ADDR_W-1:0] payload_addr;
    logic [TOT_LEN_W-1:0]         payload_len;
  } payload_buf_struct;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR_OUT = 2'd1,
    ST_DATA    = 2'd2,
    ST_FREE    = 2'd3
  } drain_state_e;

  // Number of MAC lines covering len bytes (rounded up).
  function automatic logic [TOT_LEN_W-1:0] len_to_lines(input logic [TOT_LEN_W-1:0] len);
    return (len >> MAC_INTERFACE_BYTES_W) +
           TOT_LEN_W'(len[MAC_INTERFACE_BYTES_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/tcp_tmp_rx_buf_drain_ctrl.sv
// Drain sequencing FSM: entry accept, header out, data phase, slab free.
module tcp_tmp_rx_buf_drain_ctrl
  import tcp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         src_hdr_val,
  input  logic         dst_hdr_rdy,
  input  logic         free_rdy,
  input  logic         len_zero,
  input  logic         last_beat_hs,
  output drain_state_e state,
  output logic         entry_accept,
  output logic         hdr_rdy,
  output logic         dst_hdr_val,
  output logic         free_val
);

  assign entry_accept = hdr_rdy && src_hdr_val;

  // hdr_rdy is only ever high in IDLE, so accept needs no state qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      hdr_rdy     <= 1'b0;
      dst_hdr_val <= 1'b0;
      free_val    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (entry_accept) begin
            state       <= ST_HDR_OUT;
            hdr_rdy     <= 1'b0;
            dst_hdr_val <= 1'b1;
          end else begin
            hdr_rdy <= 1'b1;
          end
        end
        ST_HDR_OUT: begin
          if (dst_hdr_rdy) begin
            dst_hdr_val <= 1'b0;
            if (len_zero) begin
              state    <= ST_FREE;
              free_val <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (last_beat_hs) begin
            state    <= ST_FREE;
            free_val <= 1'b1;
          end
        end
        ST_FREE: begin
          if (free_rdy) begin
            state    <= ST_IDLE;
            free_val <= 1'b0;
            hdr_rdy  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          hdr_rdy     <= 1'b0;
          dst_hdr_val <= 1'b0;
          free_val    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tcp_tmp_rx_buf_drain_datapath.sv
// Entry field registers, line address/request/response counters and beat shaping.
module tcp_tmp_rx_buf_drain_datapath
  import tcp_pkg::*;
  import packet_struct_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             in_data,
  input  logic [IP_ADDR_W-1:0]             src_ip,
  input  logic [IP_ADDR_W-1:0]             dst_ip,
  input  tcp_pkt_hdr                       tcp_hdr,
  input  payload_buf_struct                entry,
  output logic [IP_ADDR_W-1:0]             src_ip_q,
  output logic [IP_ADDR_W-1:0]             dst_ip_q,
  output tcp_pkt_hdr                       tcp_hdr_q,
  output logic [TOT_LEN_W-1:0]             len_q,
  output logic [RX_TMP_BUF_ADDR_W-1:0]     slab_addr_q,
  output logic                             len_zero,
  output logic                             rd_req_val,
  output logic [RX_TMP_BUF_MEM_ADDR_W-1:0] rd_req_addr,
  input  logic                             rd_req_rdy,
  input  logic                             resp_val,
  input  logic [MAC_INTERFACE_W-1:0]       resp_data,
  output logic                             resp_rdy,
  output logic                             data_val,
  output logic [MAC_INTERFACE_W-1:0]       data,
  output logic                             data_last,
  output logic [MAC_PADBYTES_W-1:0]        data_padbytes,
  input  logic                             data_rdy,
  output logic                             last_beat_hs
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [TOT_LEN_W-1:0]      req_left;
  logic [TOT_LEN_W-1:0]      resp_left;
  logic [OUT_W-1:0]          outstanding;
  logic [MAC_PADBYTES_W-1:0] pad_bytes;
  logic                      req_hs;
  logic                      beat_hs;

  assign len_zero   = (len_q == '0);
  assign rd_req_val = in_data && (req_left != '0) && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign req_hs     = rd_req_val && rd_req_rdy;

  // Responses arrive in order, so they pass straight through as payload beats.
  assign resp_rdy     = in_data && data_rdy;
  assign data_val     = in_data && resp_val;
  assign data         = resp_data;
  assign beat_hs      = data_val && data_rdy;
  assign data_last    = (resp_left == TOT_LEN_W'(1));
  assign last_beat_hs = beat_hs && data_last;

  // Modular subtraction gives (BYTES - len%BYTES) % BYTES directly.
  assign pad_bytes     = MAC_PADBYTES_W'(MAC_INTERFACE_BYTES) - len_q[MAC_INTERFACE_BYTES_W-1:0];
  assign data_padbytes = data_last ? pad_bytes : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      tcp_hdr_q   <= '0;
      len_q       <= '0;
      slab_addr_q <= '0;
      rd_req_addr <= '0;
      req_left    <= '0;
      resp_left   <= '0;
      outstanding <= '0;
    end else if (load) begin
      src_ip_q    <= src_ip;
      dst_ip_q    <= dst_ip;
      tcp_hdr_q   <= tcp_hdr;
      len_q       <= entry.payload_len;
      slab_addr_q <= entry.payload_addr;
      rd_req_addr <= entry.payload_addr[RX_TMP_BUF_ADDR_W-1:MAC_INTERFACE_BYTES_W];
      req_left    <= len_to_lines(entry.payload_len);
      resp_left   <= len_to_lines(entry.payload_len);
      outstanding <= '0;
    end else begin
      if (req_hs) begin
        rd_req_addr <= rd_req_addr + 1'b1;
        req_left    <= req_left - 1'b1;
      end
      if (beat_hs) resp_left <= resp_left - 1'b1;
      case ({req_hs, beat_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: rtl/tcp_tmp_rx_buf_drain.sv
// Drains completed tmp RX buffer entries: header, payload lines, slab free.
// Optional TCP_RX_DRAIN_STATS_EN adds packet/byte counters.
module tcp_tmp_rx_buf_drain
  import tcp_pkg::*;
  import packet_struct_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             src_drain_rx_hdr_val,
  input  logic [IP_ADDR_W-1:0]             src_drain_rx_src_ip,
  input  logic [IP_ADDR_W-1:0]             src_drain_rx_dst_ip,
  input  tcp_pkt_hdr                       src_drain_rx_tcp_hdr,
  input  payload_buf_struct                src_drain_rx_payload_entry,
  output logic                             drain_src_rx_hdr_rdy,
  output logic                             drain_buf_rd_req_val,
  output logic [RX_TMP_BUF_MEM_ADDR_W-1:0] drain_buf_rd_req_addr,
  input  logic                             buf_drain_rd_req_rdy,
  input  logic                             buf_drain_rd_resp_val,
  input  logic [MAC_INTERFACE_W-1:0]       buf_drain_rd_resp_data,
  output logic                             drain_buf_rd_resp_rdy,
  output logic                             drain_dst_rx_hdr_val,
  output logic [IP_ADDR_W-1:0]             drain_dst_rx_src_ip,
  output logic [IP_ADDR_W-1:0]             drain_dst_rx_dst_ip,
  output tcp_pkt_hdr                       drain_dst_rx_tcp_hdr,
  output logic [TOT_LEN_W-1:0]             drain_dst_rx_payload_len,
  input  logic                             dst_drain_rx_hdr_rdy,
  output logic                             drain_dst_rx_data_val,
  output logic [MAC_INTERFACE_W-1:0]       drain_dst_rx_data,
  output logic                             drain_dst_rx_data_last,
  output logic [MAC_PADBYTES_W-1:0]        drain_dst_rx_data_padbytes,
  input  logic                             dst_drain_rx_data_rdy,
  output logic                             drain_free_slab_req_val,
  output logic [RX_TMP_BUF_ADDR_W-1:0]     drain_free_slab_req_addr,
  input  logic                             free_slab_drain_req_rdy
`ifdef TCP_RX_DRAIN_STATS_EN
  ,
  output logic [31:0]                      drain_stats_pkts,
  output logic [31:0]                      drain_stats_bytes
`endif
);

  drain_state_e state;
  logic         entry_accept;
  logic         in_data;
  logic         len_zero;
  logic         last_beat_hs;

  assign in_data = (state == ST_DATA);

  tcp_tmp_rx_buf_drain_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .src_hdr_val  (src_drain_rx_hdr_val),
    .dst_hdr_rdy  (dst_drain_rx_hdr_rdy),
    .free_rdy     (free_slab_drain_req_rdy),
    .len_zero     (len_zero),
    .last_beat_hs (last_beat_hs),
    .state        (state),
    .entry_accept (entry_accept),
    .hdr_rdy      (drain_src_rx_hdr_rdy),
    .dst_hdr_val  (drain_dst_rx_hdr_val),
    .free_val     (drain_free_slab_req_val)
  );

  tcp_tmp_rx_buf_drain_datapath #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_dp (
    .clk           (clk),
    .rst           (rst),
    .load          (entry_accept),
    .in_data       (in_data),
    .src_ip        (src_drain_rx_src_ip),
    .dst_ip        (src_drain_rx_dst_ip),
    .tcp_hdr       (src_drain_rx_tcp_hdr),
    .entry         (src_drain_rx_payload_entry),
    .src_ip_q      (drain_dst_rx_src_ip),
    .dst_ip_q      (drain_dst_rx_dst_ip),
    .tcp_hdr_q     (drain_dst_rx_tcp_hdr),
    .len_q         (drain_dst_rx_payload_len),
    .slab_addr_q   (drain_free_slab_req_addr),
    .len_zero      (len_zero),
    .rd_req_val    (drain_buf_rd_req_val),
    .rd_req_addr   (drain_buf_rd_req_addr),
    .rd_req_rdy    (buf_drain_rd_req_rdy),
    .resp_val      (buf_drain_rd_resp_val),
    .resp_data     (buf_drain_rd_resp_data),
    .resp_rdy      (drain_buf_rd_resp_rdy),
    .data_val      (drain_dst_rx_data_val),
    .data          (drain_dst_rx_data),
    .data_last     (drain_dst_rx_data_last),
    .data_padbytes (drain_dst_rx_data_padbytes),
    .data_rdy      (dst_drain_rx_data_rdy),
    .last_beat_hs  (last_beat_hs)
  );

`ifdef TCP_RX_DRAIN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_stats_pkts  <= '0;
      drain_stats_bytes <= '0;
    end else if (drain_free_slab_req_val && free_slab_drain_req_rdy) begin
      drain_stats_pkts  <= drain_stats_pkts + 32'd1;
      drain_stats_bytes <= drain_stats_bytes + 32'(drain_dst_rx_payload_len);
    end
  end
`endif

  // A response with no request in flight means the buffer broke the protocol.
  resp_only_in_data: assert property (@(posedge clk) disable iff (rst)
    buf_drain_rd_resp_val |-> in_data);

endmodule

// File: tb/tb_tcp_tmp_rx_buf_drain.sv
// Randomized directed bench for tcp_tmp_rx_buf_drain with an event-queue reference model.
module tb_tcp_tmp_rx_buf_drain;
  import tcp_pkg::*;
  import packet_struct_pkg::*;

  localparam int MAXO  = 2;
  localparam int BYTES = MAC_INTERFACE_BYTES;
  localparam int NLINE = 1 << RX_TMP_BUF_MEM_ADDR_W;

  logic clk = 1'b0;
  logic rst;
  logic src_drain_rx_hdr_val;
  logic [IP_ADDR_W-1:0] src_drain_rx_src_ip, src_drain_rx_dst_ip;
  tcp_pkt_hdr src_drain_rx_tcp_hdr;
  payload_buf_struct src_drain_rx_payload_entry;
  logic drain_src_rx_hdr_rdy;
  logic drain_buf_rd_req_val;
  logic [RX_TMP_BUF_MEM_ADDR_W-1:0] drain_buf_rd_req_addr;
  logic buf_drain_rd_req_rdy, buf_drain_rd_resp_val, drain_buf_rd_resp_rdy;
  logic [MAC_INTERFACE_W-1:0] buf_drain_rd_resp_data;
  logic drain_dst_rx_hdr_val, dst_drain_rx_hdr_rdy;
  logic [IP_ADDR_W-1:0] drain_dst_rx_src_ip, drain_dst_rx_dst_ip;
  tcp_pkt_hdr drain_dst_rx_tcp_hdr;
  logic [TOT_LEN_W-1:0] drain_dst_rx_payload_len;
  logic drain_dst_rx_data_val, drain_dst_rx_data_last, dst_drain_rx_data_rdy;
  logic [MAC_INTERFACE_W-1:0] drain_dst_rx_data;
  logic [MAC_PADBYTES_W-1:0] drain_dst_rx_data_padbytes;
  logic drain_free_slab_req_val, free_slab_drain_req_rdy;
  logic [RX_TMP_BUF_ADDR_W-1:0] drain_free_slab_req_addr;
`ifdef TCP_RX_DRAIN_STATS_EN
  logic [31:0] drain_stats_pkts, drain_stats_bytes;
`endif

  always #5 clk = ~clk;

  tcp_tmp_rx_buf_drain #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .src_drain_rx_hdr_val(src_drain_rx_hdr_val), .src_drain_rx_src_ip(src_drain_rx_src_ip),
    .src_drain_rx_dst_ip(src_drain_rx_dst_ip), .src_drain_rx_tcp_hdr(src_drain_rx_tcp_hdr),
    .src_drain_rx_payload_entry(src_drain_rx_payload_entry), .drain_src_rx_hdr_rdy(drain_src_rx_hdr_rdy),
    .drain_buf_rd_req_val(drain_buf_rd_req_val), .drain_buf_rd_req_addr(drain_buf_rd_req_addr),
    .buf_drain_rd_req_rdy(buf_drain_rd_req_rdy), .buf_drain_rd_resp_val(buf_drain_rd_resp_val),
    .buf_drain_rd_resp_data(buf_drain_rd_resp_data), .drain_buf_rd_resp_rdy(drain_buf_rd_resp_rdy),
    .drain_dst_rx_hdr_val(drain_dst_rx_hdr_val), .drain_dst_rx_src_ip(drain_dst_rx_src_ip),
    .drain_dst_rx_dst_ip(drain_dst_rx_dst_ip), .drain_dst_rx_tcp_hdr(drain_dst_rx_tcp_hdr),
    .drain_dst_rx_payload_len(drain_dst_rx_payload_len), .dst_drain_rx_hdr_rdy(dst_drain_rx_hdr_rdy),
    .drain_dst_rx_data_val(drain_dst_rx_data_val), .drain_dst_rx_data(drain_dst_rx_data),
    .drain_dst_rx_data_last(drain_dst_rx_data_last), .drain_dst_rx_data_padbytes(drain_dst_rx_data_padbytes),
    .dst_drain_rx_data_rdy(dst_drain_rx_data_rdy), .drain_free_slab_req_val(drain_free_slab_req_val),
    .drain_free_slab_req_addr(drain_free_slab_req_addr), .free_slab_drain_req_rdy(free_slab_drain_req_rdy)
`ifdef TCP_RX_DRAIN_STATS_EN
    , .drain_stats_pkts(drain_stats_pkts), .drain_stats_bytes(drain_stats_bytes)
`endif
  );

  typedef struct {
    logic [MAC_INTERFACE_W-1:0] d;
    logic                       last;
    int                         pad;
  } beat_t;

  // Reference model state: tmp-buffer contents and per-packet expected events.
  logic [MAC_INTERFACE_W-1:0] mem [NLINE];
  int    mem_q[$];
  int    exp_reqs[$];
  beat_t exp_beats[$];
  int    exp_free[$];
  bit    hdr_pending, src_pending;
  logic [IP_ADDR_W-1:0] exp_src_ip, exp_dst_ip;
  tcp_pkt_hdr exp_tcp;
  int    exp_len;
  int    req_pct, resp_pct, hdr_pct, data_pct, free_pct;
  longint model_pkts, model_bytes;
  int    vectors, miscompares;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, score handshakes taken at the next posedge.
  task automatic cycle();
    @(negedge clk);
    src_drain_rx_hdr_val   = src_pending;
    buf_drain_rd_resp_val  = (mem_q.size() != 0) && ($urandom_range(0, 99) < resp_pct);
    buf_drain_rd_resp_data = '0;
    if (buf_drain_rd_resp_val) buf_drain_rd_resp_data = mem[mem_q[0]];
    buf_drain_rd_req_rdy    = $urandom_range(0, 99) < req_pct;
    dst_drain_rx_hdr_rdy    = $urandom_range(0, 99) < hdr_pct;
    dst_drain_rx_data_rdy   = $urandom_range(0, 99) < data_pct;
    free_slab_drain_req_rdy = $urandom_range(0, 99) < free_pct;
    #1;
    if (src_drain_rx_hdr_val && drain_src_rx_hdr_rdy) src_pending = 0;
    if (drain_dst_rx_hdr_val && dst_drain_rx_hdr_rdy) begin
      chk("hdr_expected", hdr_pending, 1);
      chk("hdr_src_ip", drain_dst_rx_src_ip, exp_src_ip);
      chk("hdr_dst_ip", drain_dst_rx_dst_ip, exp_dst_ip);
      chk("hdr_tcp", drain_dst_rx_tcp_hdr, exp_tcp);
      chk("hdr_len", drain_dst_rx_payload_len, exp_len);
      hdr_pending = 0;
    end
    if (drain_buf_rd_req_val && buf_drain_rd_req_rdy) begin
      chk("req_expected", exp_reqs.size() != 0, 1);
      chk("req_after_hdr", hdr_pending, 0);
      if (exp_reqs.size() != 0) chk("req_addr", drain_buf_rd_req_addr, exp_reqs.pop_front());
      mem_q.push_back(int'(drain_buf_rd_req_addr));
    end
    if (buf_drain_rd_resp_val && drain_buf_rd_resp_rdy) void'(mem_q.pop_front());
    if (drain_dst_rx_data_val && dst_drain_rx_data_rdy) begin
      chk("beat_expected", exp_beats.size() != 0, 1);
      if (exp_beats.size() != 0) begin
        beat_t b = exp_beats.pop_front();
        chk("beat_data", drain_dst_rx_data, b.d);
        chk("beat_last", drain_dst_rx_data_last, b.last);
        chk("beat_padbytes", drain_dst_rx_data_padbytes, b.pad);
      end
    end
    if (drain_free_slab_req_val && free_slab_drain_req_rdy) begin
      chk("free_expected", exp_free.size() != 0, 1);
      chk("free_after_data", exp_beats.size(), 0);
      chk("no_accept_during_free", drain_src_rx_hdr_rdy, 0);
      if (exp_free.size() != 0) chk("free_addr", drain_free_slab_req_addr, exp_free.pop_front());
      model_pkts++;
      model_bytes += exp_len;
    end
    chk("outstanding_max", mem_q.size() <= MAXO, 1);
  endtask

  task automatic setup_pkt(input int addr, input int len);
    int lines, base, ln;
    lines = (len + BYTES - 1) / BYTES;
    base  = (addr % (1 << RX_TMP_BUF_ADDR_W)) / BYTES;
    src_drain_rx_src_ip = $urandom();
    src_drain_rx_dst_ip = $urandom();
    src_drain_rx_tcp_hdr = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    src_drain_rx_payload_entry.payload_addr = RX_TMP_BUF_ADDR_W'(addr);
    src_drain_rx_payload_entry.payload_len  = TOT_LEN_W'(len);
    exp_src_ip = src_drain_rx_src_ip;
    exp_dst_ip = src_drain_rx_dst_ip;
    exp_tcp    = src_drain_rx_tcp_hdr;
    exp_len    = len;
    for (int i = 0; i < lines; i++) begin
      beat_t b;
      ln     = (base + i) % NLINE;
      b.d    = mem[ln];
      b.last = (i == lines - 1);
      b.pad  = b.last ? (BYTES - len % BYTES) % BYTES : 0;
      exp_reqs.push_back(ln);
      exp_beats.push_back(b);
    end
    exp_free.push_back(addr % (1 << RX_TMP_BUF_ADDR_W));
    hdr_pending = 1;
    src_pending = 1;
  endtask

  task automatic finish_pkt();
    int n = 0;
    while (exp_free.size() != 0 && n < 3000) begin
      cycle();
      n++;
    end
    chk("pkt_completed", exp_free.size(), 0);
    chk("pkt_reqs_left", exp_reqs.size(), 0);
    chk("pkt_beats_left", exp_beats.size(), 0);
    exp_free.delete(); exp_reqs.delete(); exp_beats.delete();
    hdr_pending = 0;
  endtask

  task automatic run_pkt(input int addr, input int len);
    setup_pkt(addr, len);
    finish_pkt();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_hdr_rdy"}, drain_src_rx_hdr_rdy, 0);
    chk({tag, "_req_val"}, drain_buf_rd_req_val, 0);
    chk({tag, "_hdr_val"}, drain_dst_rx_hdr_val, 0);
    chk({tag, "_data_val"}, drain_dst_rx_data_val, 0);
    chk({tag, "_free_val"}, drain_free_slab_req_val, 0);
`ifdef TCP_RX_DRAIN_STATS_EN
    chk({tag, "_stats_pkts"}, drain_stats_pkts, 0);
    chk({tag, "_stats_bytes"}, drain_stats_bytes, 0);
`endif
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0; model_pkts = 0; model_bytes = 0;
    rst = 1'b1;
    src_drain_rx_hdr_val = 0; src_drain_rx_src_ip = '0; src_drain_rx_dst_ip = '0;
    src_drain_rx_tcp_hdr = '0; src_drain_rx_payload_entry = '0;
    buf_drain_rd_req_rdy = 0; buf_drain_rd_resp_val = 0; buf_drain_rd_resp_data = '0;
    dst_drain_rx_hdr_rdy = 0; dst_drain_rx_data_rdy = 0; free_slab_drain_req_rdy = 0;
    req_pct = 100; resp_pct = 100; hdr_pct = 100; data_pct = 100; free_pct = 100;
    hdr_pending = 0; src_pending = 0;
    for (int i = 0; i < NLINE; i++)
      for (int k = 0; k < MAC_INTERFACE_W / 32; k++) mem[i][k*32 +: 32] = $urandom();

    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("hdr_rdy_after_reset", drain_src_rx_hdr_rdy, 1);

    run_pkt(32'h040, 0);                        // empty payload: header then free only
    run_pkt(0, BYTES * 3);                      // three full lines
    run_pkt(32'h123, BYTES + 5);                // partial last line
    run_pkt((NLINE - 1) * BYTES, BYTES * 2);    // line address wraps to 0

    // Downstream stall: outstanding must saturate at MAXO and order survive.
    data_pct = 0;
    setup_pkt(32'h200, BYTES * 6);
    n = 0;
    while (mem_q.size() == 0 && n < 100) begin cycle(); n++; end
    repeat (10) cycle();
    chk("outstanding_full", mem_q.size(), MAXO);
    data_pct = 100;
    finish_pkt();

    for (int p = 0; p < 14; p++) begin
      req_pct  = $urandom_range(30, 100);
      resp_pct = $urandom_range(30, 100);
      hdr_pct  = $urandom_range(30, 100);
      data_pct = $urandom_range(30, 100);
      free_pct = $urandom_range(30, 100);
      run_pkt($urandom_range(0, (1 << RX_TMP_BUF_ADDR_W) - 1), $urandom_range(0, 7 * BYTES));
    end
    req_pct = 100; resp_pct = 100; hdr_pct = 100; free_pct = 100;

    // Reset in the middle of the data phase: entry dropped, nothing freed.
    data_pct = 0;
    setup_pkt(32'h300, BYTES * 4);
    n = 0;
    while (mem_q.size() == 0 && n < 100) begin cycle(); n++; end
    chk("reset_test_in_data", mem_q.size() != 0, 1);
    @(negedge clk);
    rst = 1'b1;
    buf_drain_rd_resp_val = 0; src_drain_rx_hdr_val = 0; src_pending = 0;
    mem_q.delete(); exp_reqs.delete(); exp_beats.delete(); exp_free.delete();
    hdr_pending = 0; model_pkts = 0; model_bytes = 0;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    data_pct = 100;
    cycle();
    chk("idle_after_reset", drain_src_rx_hdr_rdy, 1);
    repeat (5) begin
      cycle();
      chk("no_free_after_reset", drain_free_slab_req_val, 0);
    end

    run_pkt($urandom_range(0, 4095), 0);
    run_pkt($urandom_range(0, 4095), 10);
    run_pkt($urandom_range(0, 4095), 64);
    chk("model_pkts_after_reset", model_pkts, 3);
`ifdef TCP_RX_DRAIN_STATS_EN
    chk("stats_pkts", drain_stats_pkts, model_pkts);
    chk("stats_bytes", drain_stats_bytes, model_bytes);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
